// File: rtl/sq_out_carry_resolve_if.sv
// +----------------------------------------------------------------------------+
// | sq_out_carry_resolve_if                                                    |
// | Output word stream (valid/ready) of the redundant-to-binary carry resolver |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sq_out_carry_resolve_if #(
  parameter int WORD_LEN = 50,
  parameter int IDX_W    = 5
);
  logic                out_valid;
  logic                out_ready;
  logic [WORD_LEN-1:0] out_word;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;
  logic                overflow;

  modport master (
    output out_valid,
    output out_word,
    output out_idx,
    output out_last,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    input  out_idx,
    input  out_last,
    input  overflow,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/sq_out_carry_resolve.sv
// +----------------------------------------------------------------------------+
// | sq_out_carry_resolve                                                       |
// | Snapshots redundant squarer digits and streams carry-resolved words LSW 1st|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sq_out_carry_resolve #(
  parameter int NUM_ELEMENTS = 21,
  parameter int WORD_LEN     = 50,
  parameter int IDX_W        = 5
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                start,
  input  wire logic [WORD_LEN:0]   sq_in [NUM_ELEMENTS],
  output logic                     busy,
  output logic                     done,
  sq_out_carry_resolve_if.master   out_if
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);
  localparam int               C_SUM_W    = WORD_LEN + 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_LEN:0]   r_buf [NUM_ELEMENTS];
  logic [WORD_LEN-1:0] r_word;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_carry;
  logic                r_last;
  logic                r_ovf;
  logic                r_done;

  logic                w_load;
  logic                w_first;
  logic                w_hs;
  logic [IDX_W-1:0]    w_next_idx;
  logic [WORD_LEN:0]   w_digit;
  logic [1:0]          w_cin;
  logic [C_SUM_W-1:0]  w_sum;
  logic                w_next_last;

  // Next-state and load control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_first     = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_EMIT;
          w_load      = 1'b1;
          w_first     = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_if.out_ready) begin
          w_hs = 1'b1;
          if (r_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Index selection is clamped on the last word so the buffer mux never reads past the end.
  always_comb begin
    w_next_idx  = '0;
    w_digit     = sq_in[0];
    w_cin       = 2'd0;
    if (!w_first) begin
      w_next_idx = r_last ? '0 : (r_idx + IDX_W'(1));
      w_digit    = r_buf[w_next_idx];
      w_cin      = r_carry;
    end
    w_sum       = C_SUM_W'(w_digit) + C_SUM_W'(w_cin);
    w_next_last = (w_next_idx == C_LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_carry <= 2'd0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_hs && r_last;
      if (w_load) begin
        r_word  <= w_sum[WORD_LEN-1:0];
        r_carry <= w_sum[WORD_LEN+1:WORD_LEN];
        r_idx   <= w_next_idx;
        r_last  <= w_next_last;
        r_ovf   <= w_next_last && (w_sum[WORD_LEN+1:WORD_LEN] != 2'd0);
      end else if (w_hs && r_last) begin
        r_carry <= 2'd0;
        r_last  <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  // Snapshot buffer carries no reset; its contents only matter after a start.
  always_ff @(posedge clk) begin
    if (w_first) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        r_buf[i] <= sq_in[i];
      end
    end
  end

  assign busy             = (r_state == ST_EMIT);
  assign done             = r_done;
  assign out_if.out_valid = (r_state == ST_EMIT);
  assign out_if.out_word  = r_word;
  assign out_if.out_idx   = r_idx;
  assign out_if.out_last  = r_last;
  assign out_if.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sq_out_carry_resolve.sv
// +----------------------------------------------------------------------------+
// | tb_sq_out_carry_resolve                                                    |
// | Scoreboard bench: big-integer reference model vs. streamed resolved words  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sq_out_carry_resolve;

  localparam int N  = 21;
  localparam int W  = 50;
  localparam int IW = 5;
  localparam int TW = N * W + 8;

  typedef struct {
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
    logic          last;
    logic          ovf;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W:0]    sq_in [N];
  logic [W:0]    stim  [N];
  logic          busy;
  logic          done;

  int            n_vec  = 0;
  int            n_fail = 0;
  int            rdy_mode = 0;
  int            stall_n  = 0;
  exp_t          q[$];

  sq_out_carry_resolve_if #(.WORD_LEN(W), .IDX_W(IW)) oif ();

  sq_out_carry_resolve #(
    .NUM_ELEMENTS(N),
    .WORD_LEN    (W),
    .IDX_W       (IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sq_in (sq_in),
    .busy  (busy),
    .done  (done),
    .out_if(oif.master)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void flag_fail(string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endfunction

  function automatic logic [W:0] rnd_digit();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) t = '1;
    return t[W:0];
  endfunction

  // Reference: the whole redundant number as one integer, then sliced into words.
  function automatic void push_model();
    logic [TW-1:0] total;
    exp_t          e;
    total = '0;
    for (int i = 0; i < N; i++) total += TW'(stim[i]) << (W * i);
    for (int i = 0; i < N; i++) begin
      e.word = total[i*W +: W];
      e.idx  = IW'(i);
      e.last = (i == N - 1);
      e.ovf  = e.last && (total[TW-1:N*W] != '0);
      q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: oif.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (oif.out_valid && oif.out_idx == IW'(5) && stall_n < 3) begin
          oif.out_ready = 1'b0;
          stall_n++;
        end else begin
          oif.out_ready = 1'b1;
        end
      end
      default: oif.out_ready = 1'b1;
    endcase
  end

  // Monitor: pops expected words on every observed handshake.
  logic          exp_done   = 1'b0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_word;
  logic [IW-1:0] prev_idx;
  logic          prev_last;
  exp_t          e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (prev_stall) begin
        chk("stall_word", 64'(oif.out_word), 64'(prev_word));
        chk("stall_idx",  64'(oif.out_idx),  64'(prev_idx));
        chk("stall_last", 64'(oif.out_last), 64'(prev_last));
      end
      if (oif.out_valid && oif.out_ready) begin
        if (q.size() == 0) begin
          flag_fail("unexpected_word");
        end else begin
          e_mon = q.pop_front();
          chk("word", 64'(oif.out_word), 64'(e_mon.word));
          chk("idx",  64'(oif.out_idx),  64'(e_mon.idx));
          chk("last", 64'(oif.out_last), 64'(e_mon.last));
          if (e_mon.last) begin
            chk("overflow", 64'(oif.overflow), 64'(e_mon.ovf));
            exp_done = 1'b1;
          end
        end
      end
      prev_stall = oif.out_valid && !oif.out_ready;
      prev_word  = oif.out_word;
      prev_idx   = oif.out_idx;
      prev_last  = oif.out_last;
    end
  end

  task automatic start_conv();
    sq_in = stim;
    start = 1'b1;
    push_model();
    stall_n = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) flag_fail("wait_done");
    else chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_idx(input int v);
    int cnt;
    cnt = 0;
    while (!(oif.out_valid && oif.out_idx == IW'(v)) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 400) flag_fail("wait_idx");
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_busy"},  64'(busy),           64'd0);
    chk({tag, "_valid"}, 64'(oif.out_valid),  64'd0);
    chk({tag, "_word"},  64'(oif.out_word),   64'd0);
    chk({tag, "_idx"},   64'(oif.out_idx),    64'd0);
    chk({tag, "_last"},  64'(oif.out_last),   64'd0);
    chk({tag, "_ovf"},   64'(oif.overflow),   64'd0);
    chk({tag, "_done"},  64'(done),           64'd0);
  endtask

  initial begin
    int cyc;
    oif.out_ready = 1'b1;
    for (int i = 0; i < N; i++) sq_in[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All digits 2^50, top 0: latency of done is 22 cycles from start
    for (int i = 0; i < N; i++) stim[i] = (i == N - 1) ? '0 : (51'd1 << 50);
    start_conv();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("done_latency", 64'(cyc + 1), 64'd22);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);

    // All digits max, top 2^33-1
    for (int i = 0; i < N; i++) stim[i] = (i == N - 1) ? 51'((64'd1 << 33) - 1) : '1;
    start_conv();
    wait_done(cyc);
    @(negedge clk);

    // Top and digit 19 max: overflow on last word
    for (int i = 0; i < N; i++) stim[i] = (i >= N - 2) ? '1 : '0;
    start_conv();
    wait_done(cyc);
    @(negedge clk);

    // Scripted three-cycle stall at index 5
    rdy_mode = 2;
    for (int i = 0; i < N; i++) stim[i] = rnd_digit();
    start_conv();
    wait_done(cyc);
    chk("stall_cycles", 64'(stall_n), 64'd3);
    @(negedge clk);

    // Start while busy with bus changed, then start in the done cycle
    rdy_mode = 1;
    for (int i = 0; i < N; i++) stim[i] = rnd_digit();
    start_conv();
    wait_idx(8);
    for (int i = 0; i < N; i++) sq_in[i] = rnd_digit();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", 64'(busy), 64'd1);
    wait_done(cyc);
    for (int i = 0; i < N; i++) stim[i] = rnd_digit();
    start_conv();
    chk("busy_done_cycle_start", 64'(busy), 64'd1);
    wait_done(cyc);
    @(negedge clk);

    // Random conversions under random backpressure
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) stim[i] = rnd_digit();
      start_conv();
      wait_done(cyc);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream
    rdy_mode = 0;
    for (int i = 0; i < N; i++) stim[i] = rnd_digit();
    start_conv();
    wait_idx(10);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_reset", 64'(done), 64'd0);
    for (int i = 0; i < N; i++) stim[i] = rnd_digit();
    start_conv();
    wait_done(cyc);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
